hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall sequencing, branch flush, memory-wait hold.
// Optional HAZARD_CTRL_EXMEM_EN adds EX/MEM load-use detection (single-cycle stall).
module hazard_ctrl #(
    parameter int AW           = 4,
    parameter int STALL_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ifidOP1,
    input  logic [AW-1:0] ifidOP2,
    input  logic [AW-1:0] idexOP1,
    input  logic          idexR,
    input  logic          w,
    input  logic          brtaken,
`ifdef HAZARD_CTRL_EXMEM_EN
    input  logic [AW-1:0] exmemOP1,
    input  logic          exmemR,
`endif
    output logic          pcdrive,
    output logic          stall,
    output logic          flush,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_e;

    localparam logic [3:0] CNT_INIT = 4'((STALL_CYCLES > 1) ? (STALL_CYCLES - 2) : 0);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       hit;
    logic       ex_hit;

    assign hit = idexR && (idexOP1 != '0) &&
                 ((idexOP1 == ifidOP1) || (idexOP1 == ifidOP2));

`ifdef HAZARD_CTRL_EXMEM_EN
    assign ex_hit = exmemR && (exmemOP1 != '0) &&
                    ((exmemOP1 == ifidOP1) || (exmemOP1 == ifidOP2));
`else
    assign ex_hit = 1'b0;
`endif

    // Output priority: reset, then branch flush, then memory wait, then state behaviour.
    always_comb begin
        stall = 1'b0;
        flush = 1'b0;
        if (rst) begin
            stall = 1'b1;
        end else if (brtaken) begin
            flush = 1'b1;
        end else begin
            unique case (state_q)
                IDLE:    stall = w || hit || ex_hit;
                STALL:   stall = 1'b1;
                FLUSH:   begin
                    flush = 1'b1;
                    stall = w;
                end
                default: stall = 1'b1;
            endcase
        end
        busy    = (state_q == STALL) && !rst;
        pcdrive = !stall && !rst;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (rst) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (brtaken) begin
            state_d = FLUSH;
            cnt_d   = '0;
        end else if (!w) begin
            unique case (state_q)
                IDLE: begin
                    if (hit && (STALL_CYCLES > 1)) begin
                        state_d = STALL;
                        cnt_d   = CNT_INIT;
                    end
                end
                STALL: begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                FLUSH:   state_d = IDLE;
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
    end

endmodule
